// File: rtl/armv8_regfile_sb_if.sv
// Bus bundle for the ARMv8 register file: two read ports, two write ports
// and the scoreboard issue handshake. Clock and reset stay outside.
interface armv8_regfile_sb_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] RA;
  logic [ADDR_WIDTH-1:0] RB;
  logic [DATA_WIDTH-1:0] BusA;
  logic [DATA_WIDTH-1:0] BusB;
  logic                  RdyA;
  logic                  RdyB;
  logic                  RegWrA;
  logic [ADDR_WIDTH-1:0] RWA;
  logic [DATA_WIDTH-1:0] BusWA;
  logic                  RegWrB;
  logic [ADDR_WIDTH-1:0] RWB;
  logic [DATA_WIDTH-1:0] BusWB;
  logic                  Issue;
  logic [ADDR_WIDTH-1:0] IssueRd;
  logic                  IssueOk;

  modport master (
    output RA, RB, RegWrA, RWA, BusWA, RegWrB, RWB, BusWB, Issue, IssueRd,
    input  BusA, BusB, RdyA, RdyB, IssueOk
  );

  modport slave (
    input  RA, RB, RegWrA, RWA, BusWA, RegWrB, RWB, BusWB, Issue, IssueRd,
    output BusA, BusB, RdyA, RdyB, IssueOk
  );
endinterface

// File: rtl/armv8_regfile_sb.sv
// Dual-write-port register file with per-register busy scoreboard.
// Writes land on the rising edge; an optional write-to-read bypass gives
// same-cycle visibility of write data. Port B wins on a write collision,
// and an accepted issue wins over a write clearing the same busy bit.
module armv8_regfile_sb #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31,
  parameter int BYPASS     = 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  armv8_regfile_sb_if.slave   rf
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);
  localparam bit BYP = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic                  issue_ok;

  // Issue is accepted unless the destination is busy with no write arriving now
  always_comb begin
    issue_ok = (rf.IssueRd == ZR) || !busy[rf.IssueRd] ||
               (rf.RegWrA && (rf.RWA == rf.IssueRd)) ||
               (rf.RegWrB && (rf.RWB == rf.IssueRd));
  end

  assign rf.IssueOk = issue_ok;

  // Next busy vector: writes clear, then an accepted issue sets (set wins)
  always_comb begin
    busy_nxt = busy;
    if (rf.RegWrA) busy_nxt[rf.RWA] = 1'b0;
    if (rf.RegWrB) busy_nxt[rf.RWB] = 1'b0;
    if (rf.Issue && issue_ok && (rf.IssueRd != ZR)) busy_nxt[rf.IssueRd] = 1'b1;
  end

  // Register array update; port B is applied last so it wins a collision
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (rf.RegWrA && (rf.RWA != ZR)) regs[rf.RWA] <= rf.BusWA;
      if (rf.RegWrB && (rf.RWB != ZR)) regs[rf.RWB] <= rf.BusWB;
    end
  end

  // Scoreboard busy bits
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  // Read port A: zero register, then bypass (B before A), then array
  always_comb begin
    rf.BusA = regs[rf.RA];
    rf.RdyA = !busy[rf.RA];
    if (rf.RA == ZR) begin
      rf.BusA = '0;
      rf.RdyA = 1'b1;
    end else if (BYP && rf.RegWrB && (rf.RWB == rf.RA)) begin
      rf.BusA = rf.BusWB;
      rf.RdyA = 1'b1;
    end else if (BYP && rf.RegWrA && (rf.RWA == rf.RA)) begin
      rf.BusA = rf.BusWA;
      rf.RdyA = 1'b1;
    end
  end

  // Read port B: same priority as port A
  always_comb begin
    rf.BusB = regs[rf.RB];
    rf.RdyB = !busy[rf.RB];
    if (rf.RB == ZR) begin
      rf.BusB = '0;
      rf.RdyB = 1'b1;
    end else if (BYP && rf.RegWrB && (rf.RWB == rf.RB)) begin
      rf.BusB = rf.BusWB;
      rf.RdyB = 1'b1;
    end else if (BYP && rf.RegWrA && (rf.RWA == rf.RB)) begin
      rf.BusB = rf.BusWA;
      rf.RdyB = 1'b1;
    end
  end
endmodule

// File: tb/tb_armv8_regfile_sb.sv
// Bench for armv8_regfile_sb: one instance with bypass, one without, driven
// by identical inputs and compared against an array-based reference model.
module tb_armv8_regfile_sb;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam logic [AW-1:0] ZR = 5'd31;

  logic Clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [DW-1:0] mregs [32];
  bit            mbusy [32];

  armv8_regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
  armv8_regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();

  assign if0.RA      = if1.RA;
  assign if0.RB      = if1.RB;
  assign if0.RegWrA  = if1.RegWrA;
  assign if0.RWA     = if1.RWA;
  assign if0.BusWA   = if1.BusWA;
  assign if0.RegWrB  = if1.RegWrB;
  assign if0.RWB     = if1.RWB;
  assign if0.BusWB   = if1.BusWB;
  assign if0.Issue   = if1.Issue;
  assign if0.IssueRd = if1.IssueRd;

  armv8_regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(31), .BYPASS(1)) dut1 (
    .Clk(Clk), .Reset_n(rst_n), .rf(if1)
  );
  armv8_regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(31), .BYPASS(0)) dut0 (
    .Clk(Clk), .Reset_n(rst_n), .rf(if0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] exp_bus(input bit bp, input logic [AW-1:0] a);
    if (a == ZR) return '0;
    if (bp && if1.RegWrB && if1.RWB == a) return if1.BusWB;
    if (bp && if1.RegWrA && if1.RWA == a) return if1.BusWA;
    return mregs[a];
  endfunction

  function automatic logic exp_rdy(input bit bp, input logic [AW-1:0] a);
    if (a == ZR) return 1'b1;
    if (!mbusy[a]) return 1'b1;
    return bp && ((if1.RegWrB && if1.RWB == a) || (if1.RegWrA && if1.RWA == a));
  endfunction

  function automatic logic exp_issueok();
    return (if1.IssueRd == ZR) || !mbusy[if1.IssueRd] ||
           (if1.RegWrA && if1.RWA == if1.IssueRd) ||
           (if1.RegWrB && if1.RWB == if1.IssueRd);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    if1.RegWrA = 0; if1.RWA = '0; if1.BusWA = '0;
    if1.RegWrB = 0; if1.RWB = '0; if1.BusWB = '0;
    if1.Issue = 0; if1.IssueRd = '0;
  endtask

  // Advance one clock; the model absorbs whatever is on the inputs at the edge
  task automatic step();
    logic ok;
    @(posedge Clk);
    ok = exp_issueok();
    if (if1.RegWrA && if1.RWA != ZR) mregs[if1.RWA] = if1.BusWA;
    if (if1.RegWrB && if1.RWB != ZR) mregs[if1.RWB] = if1.BusWB;
    if (if1.RegWrA) mbusy[if1.RWA] = 1'b0;
    if (if1.RegWrB) mbusy[if1.RWB] = 1'b0;
    if (if1.Issue && ok && if1.IssueRd != ZR) mbusy[if1.IssueRd] = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    if1.RA = 5'd3; if1.RB = 5'd10;
    #1;
    checks++; if (if1.BusA !== 64'd0) begin failures++; $display("FAIL reset_busa got=%h exp=0", if1.BusA); end
    checks++; if (if1.RdyA !== 1'b1) begin failures++; $display("FAIL reset_rdya got=%b exp=1", if1.RdyA); end
    checks++; if (if1.IssueOk !== 1'b1) begin failures++; $display("FAIL reset_issueok got=%b exp=1", if1.IssueOk); end
    @(negedge Clk);
    rst_n = 1'b1;
    model_clear();
    if1.RegWrA = 1; if1.RWA = 5'd3; if1.BusWA = 64'hDEAD;
    if1.Issue = 1; if1.IssueRd = 5'd10;
    step();
    idle();
    #1;
    checks++; if (if1.BusA !== 64'hDEAD) begin failures++; $display("FAIL pre_reset_r3 got=%h exp=dead", if1.BusA); end
    checks++; if (if1.RdyB !== 1'b0) begin failures++; $display("FAIL pre_reset_busy10 got=%b exp=0", if1.RdyB); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (if1.BusA !== 64'd0) begin failures++; $display("FAIL async_reset_busa got=%h exp=0", if1.BusA); end
    checks++; if (if0.BusA !== 64'd0) begin failures++; $display("FAIL async_reset_busa_nb got=%h exp=0", if0.BusA); end
    checks++; if (if1.RdyB !== 1'b1) begin failures++; $display("FAIL async_reset_rdyb got=%b exp=1", if1.RdyB); end
    model_clear();
    for (int i = 0; i < 32; i++) begin
      if1.RA = 5'(i);
      #1;
      checks++;
      if (if1.RdyA !== 1'b1 || if1.BusA !== 64'd0) begin
        failures++; $display("FAIL reset_clear r%0d rdy=%b bus=%h exp rdy=1 bus=0", i, if1.RdyA, if1.BusA);
      end
    end
    @(negedge Clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    if1.RegWrA = 1; if1.RWA = 5'd5; if1.BusWA = 64'h1234; if1.RA = 5'd5;
    #1;
    checks++; if (if1.BusA !== 64'h1234) begin failures++; $display("FAIL bypass_bus got=%h exp=1234", if1.BusA); end
    checks++; if (if1.RdyA !== 1'b1) begin failures++; $display("FAIL bypass_rdy got=%b exp=1", if1.RdyA); end
    checks++; if (if0.BusA !== 64'h0) begin failures++; $display("FAIL nobypass_old got=%h exp=0", if0.BusA); end
    step();
    idle();
    #1;
    checks++; if (if0.BusA !== 64'h1234) begin failures++; $display("FAIL nobypass_next got=%h exp=1234", if0.BusA); end
  endtask

  task automatic test_collision();
    if1.RegWrA = 1; if1.RWA = 5'd7; if1.BusWA = 64'hA;
    if1.RegWrB = 1; if1.RWB = 5'd7; if1.BusWB = 64'hB;
    if1.RA = 5'd7; if1.RB = 5'd7;
    #1;
    checks++; if (if1.BusA !== 64'hB) begin failures++; $display("FAIL collide_bypass got=%h exp=b", if1.BusA); end
    step();
    idle();
    #1;
    checks++; if (if1.BusB !== 64'hB) begin failures++; $display("FAIL collide_array got=%h exp=b", if1.BusB); end
    checks++; if (if0.BusA !== 64'hB) begin failures++; $display("FAIL collide_array_nb got=%h exp=b", if0.BusA); end
  endtask

  task automatic test_zero_reg();
    if1.RegWrA = 1; if1.RWA = ZR; if1.BusWA = 64'hFF;
    if1.Issue = 1; if1.IssueRd = ZR; if1.RA = ZR;
    #1;
    checks++; if (if1.BusA !== 64'd0) begin failures++; $display("FAIL zero_bus got=%h exp=0", if1.BusA); end
    checks++; if (if1.RdyA !== 1'b1) begin failures++; $display("FAIL zero_rdy got=%b exp=1", if1.RdyA); end
    checks++; if (if1.IssueOk !== 1'b1) begin failures++; $display("FAIL zero_issueok got=%b exp=1", if1.IssueOk); end
    step();
    idle();
    #1;
    checks++; if (if0.BusA !== 64'd0 || if0.RdyA !== 1'b1) begin failures++; $display("FAIL zero_after bus=%h rdy=%b exp 0/1", if0.BusA, if0.RdyA); end
  endtask

  task automatic test_scoreboard();
    if1.Issue = 1; if1.IssueRd = 5'd9; if1.RA = 5'd9;
    #1;
    checks++; if (if1.IssueOk !== 1'b1) begin failures++; $display("FAIL sb_first_issue got=%b exp=1", if1.IssueOk); end
    step();
    #1;
    checks++; if (if1.RdyA !== 1'b0) begin failures++; $display("FAIL sb_busy got=%b exp=0", if1.RdyA); end
    checks++; if (if1.IssueOk !== 1'b0) begin failures++; $display("FAIL sb_second_issue got=%b exp=0", if1.IssueOk); end
    step();
    if1.Issue = 0;
    if1.RegWrB = 1; if1.RWB = 5'd9; if1.BusWB = 64'h55;
    #1;
    checks++; if (if1.RdyA !== 1'b1 || if1.BusA !== 64'h55) begin failures++; $display("FAIL sb_wb_bypass rdy=%b bus=%h exp 1/55", if1.RdyA, if1.BusA); end
    checks++; if (if0.RdyA !== 1'b0) begin failures++; $display("FAIL sb_wb_nobypass rdy=%b exp=0", if0.RdyA); end
    step();
    idle();
    #1;
    checks++; if (if0.RdyA !== 1'b1 || if0.BusA !== 64'h55) begin failures++; $display("FAIL sb_after rdy=%b bus=%h exp 1/55", if0.RdyA, if0.BusA); end
  endtask

  task automatic test_set_beats_clear();
    if1.Issue = 1; if1.IssueRd = 5'd4;
    step();
    if1.RegWrA = 1; if1.RWA = 5'd4; if1.BusWA = 64'h77; if1.RA = 5'd4;
    #1;
    checks++; if (if1.IssueOk !== 1'b1) begin failures++; $display("FAIL sbc_issueok got=%b exp=1", if1.IssueOk); end
    step();
    idle();
    #1;
    checks++; if (if0.BusA !== 64'h77) begin failures++; $display("FAIL sbc_data got=%h exp=77", if0.BusA); end
    checks++; if (if1.RdyA !== 1'b0) begin failures++; $display("FAIL sbc_busy got=%b exp=0", if1.RdyA); end
    if1.RegWrB = 1; if1.RWB = 5'd4; if1.BusWB = 64'h78;
    step();
    idle();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 4) == 0) ? ZR : 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if1.RegWrA  = ($urandom_range(0, 2) == 0);
      if1.RWA     = rnd_addr();
      if1.BusWA   = {$urandom, $urandom};
      if1.RegWrB  = ($urandom_range(0, 2) == 0);
      if1.RWB     = rnd_addr();
      if1.BusWB   = {$urandom, $urandom};
      if1.Issue   = ($urandom_range(0, 1) == 0);
      if1.IssueRd = rnd_addr();
      if1.RA      = rnd_addr();
      if1.RB      = rnd_addr();
      #1;
      checks++; if (if1.BusA !== exp_bus(1, if1.RA)) begin failures++; $display("FAIL rnd_busa_byp n=%0d got=%h exp=%h", n, if1.BusA, exp_bus(1, if1.RA)); end
      checks++; if (if1.BusB !== exp_bus(1, if1.RB)) begin failures++; $display("FAIL rnd_busb_byp n=%0d got=%h exp=%h", n, if1.BusB, exp_bus(1, if1.RB)); end
      checks++; if (if0.BusA !== exp_bus(0, if1.RA)) begin failures++; $display("FAIL rnd_busa_nb n=%0d got=%h exp=%h", n, if0.BusA, exp_bus(0, if1.RA)); end
      checks++; if (if0.BusB !== exp_bus(0, if1.RB)) begin failures++; $display("FAIL rnd_busb_nb n=%0d got=%h exp=%h", n, if0.BusB, exp_bus(0, if1.RB)); end
      checks++; if (if1.RdyA !== exp_rdy(1, if1.RA)) begin failures++; $display("FAIL rnd_rdya_byp n=%0d got=%b exp=%b", n, if1.RdyA, exp_rdy(1, if1.RA)); end
      checks++; if (if1.RdyB !== exp_rdy(1, if1.RB)) begin failures++; $display("FAIL rnd_rdyb_byp n=%0d got=%b exp=%b", n, if1.RdyB, exp_rdy(1, if1.RB)); end
      checks++; if (if0.RdyA !== exp_rdy(0, if1.RA)) begin failures++; $display("FAIL rnd_rdya_nb n=%0d got=%b exp=%b", n, if0.RdyA, exp_rdy(0, if1.RA)); end
      checks++; if (if0.RdyB !== exp_rdy(0, if1.RB)) begin failures++; $display("FAIL rnd_rdyb_nb n=%0d got=%b exp=%b", n, if0.RdyB, exp_rdy(0, if1.RB)); end
      checks++; if (if1.IssueOk !== exp_issueok()) begin failures++; $display("FAIL rnd_issueok n=%0d got=%b exp=%b", n, if1.IssueOk, exp_issueok()); end
      checks++; if (if0.IssueOk !== exp_issueok()) begin failures++; $display("FAIL rnd_issueok_nb n=%0d got=%b exp=%b", n, if0.IssueOk, exp_issueok()); end
      step();
    end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle();
    if1.RA = '0; if1.RB = '0;
    model_clear();
    test_reset();
    test_bypass();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_set_beats_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/armv8_regfile_sb.md
# armv8_regfile_sb

Parametrised dual-write-port register file with an integrated ready scoreboard, for the ARMv8 datapath. It replaces the single-port, negedge-write register file. Writes now happen on the rising edge, and a write-to-read bypass keeps the same-cycle visibility the negedge write used to give. A per-register busy bit lets decode detect RAW hazards against in-flight producers, such as long-latency or load results returning on the second write port.

## Interface

- DATA_WIDTH, 64, register and bus width
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- ZERO_REG, 31, index hardwired to zero (XZR); reads return 0, writes and issues are ignored
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array contents only

- Clk  input  1  clock; all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- RA, RB  input  ADDR_WIDTH  read addresses
- BusA, BusB  output  DATA_WIDTH  read data (combinational)
- RdyA, RdyB  output  1  operand valid: register not busy, or bypass hit
- RegWrA  input  1  write enable, port A (ALU writeback)
- RWA  input  ADDR_WIDTH  write address, port A
- BusWA  input  DATA_WIDTH  write data, port A
- RegWrB  input  1  write enable, port B (memory/long-latency writeback)
- RWB  input  ADDR_WIDTH  write address, port B
- BusWB  input  DATA_WIDTH  write data, port B
- Issue  input  1  mark IssueRd as pending (producer dispatched)
- IssueRd  input  ADDR_WIDTH  destination being issued
- IssueOk  output  1  issue will be accepted this cycle

## Operation

- State consists of the register array `regs[NUM_REGS]` and the busy vector `busy[NUM_REGS]`.
- Reset (Reset_n low, asynchronous): every regs entry = 0 and every busy bit = 0, taking effect immediately. Outputs follow combinationally: BusA = BusB = 0, and RdyA = RdyB = 1 when there are no writes in flight.
- Writes:
  - On a rising edge, if RegWrA and RWA != ZERO_REG, then regs[RWA] <= BusWA. Same rule for port B.
  - If RWA == RWB and both ports are enabled, port B wins.
  - A write clears busy for its address.
- Issue:
  - IssueOk = (IssueRd == ZERO_REG) || !busy[IssueRd] || (a write to IssueRd is enabled this cycle).
  - On a rising edge, if Issue && IssueOk && IssueRd != ZERO_REG, set busy[IssueRd].
  - Set beats clear: an issue and a write to the same register in the same cycle leave busy = 1, and the data is still written.
  - Issue with !IssueOk is ignored. Upstream must hold the request and stall.
- Read (shown for port A; port B is identical):
  - RA == ZERO_REG gives BusA = 0 and RdyA = 1.
  - Otherwise, with BYPASS = 1: if RegWrB && RWB == RA, BusA = BusWB. Else if RegWrA && RWA == RA, BusA = BusWA. Else BusA = regs[RA].
  - With BYPASS = 0: BusA = regs[RA].
  - RdyA = !busy[RA], or a bypass hit (BYPASS = 1 only).
- No arithmetic is performed; data passes through unmodified at DATA_WIDTH.

## Timing

- Read path: zero-cycle combinational from RA/RB, the write ports and the busy state.
- Write latency: data is visible in the array one edge after RegWrA/B. With BYPASS = 1, data is also visible on BusA/B in the same cycle.
- Scoreboard: busy is set at the edge where Issue is accepted. RdyX is low from the next cycle until the cycle a write to that register is presented. RdyX is high in that write cycle if BYPASS = 1, otherwise from the following cycle.
- Reset asserted mid-operation discards any pending writes and all busy bits. The first write is accepted on the first rising edge after Reset_n goes high.

## Test plan

- Reset: write 0xDEAD to R3, assert Reset_n low mid-cycle -> BusA reads 0 immediately for RA = 3; busy is all-zero.
- Bypass: BYPASS = 1, RegWrA with RWA = 5, BusWA = 0x1234, RA = 5 in the same cycle -> BusA = 0x1234 and RdyA = 1. With BYPASS = 0, BusA holds the old value (0) until the next cycle.
- Port collision: RWA = RWB = 7, BusWA = 0xA, BusWB = 0xB -> next cycle regs[7] = 0xB. The same-cycle bypass also shows 0xB.
- Zero register: write 0xFF to R31 and Issue R31 -> BusA = 0 and RdyA = 1 with RA = 31. IssueOk = 1 and busy[31] stays 0.
- Scoreboard: Issue R9 -> next cycle RdyA = 0 for RA = 9, and a second Issue R9 gets IssueOk = 0 and is ignored. RegWrB to R9 = 0x55 -> RdyA = 1 and BusA = 0x55 that cycle. Busy is clear afterwards.
- Set-beats-clear: Issue R4 and RegWrA R4 = 0x77 in the same cycle while busy[4] = 1 -> next cycle regs[4] = 0x77 and busy[4] = 1 (RdyA = 0).
